// File: rtl/status_flag_reader.sv
// Sticky event flags with atomic read-and-clear snapshot and maskable irq; STATUS_FLAG_CNT_EN adds per-flag saturating counters.
// Latency: event visible in flags/irq after 1 edge; snapshot valid 1 cycle after req; min read period 3 cycles.
// Backpressure: snapshot held in VALID until ack; req ignored outside IDLE, ack ignored outside VALID.
module status_flag_reader #(
  parameter int N_FLAGS   = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_arst_n,
  input  logic [N_FLAGS-1:0]             i_evt,
  input  logic [N_FLAGS-1:0]             i_mask,
  input  logic                           i_rd_req,
  input  logic                           i_rd_ack,
  output logic                           o_rd_valid,
  output logic [N_FLAGS-1:0]             o_rd_data,
  output logic [N_FLAGS*CNT_WIDTH-1:0]   o_rd_cnt,
  output logic                           o_irq,
  output logic                           o_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_VALID = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]         state_q;
  logic [N_FLAGS-1:0] flags_q;
  logic [N_FLAGS-1:0] rd_data_q;
  logic               capture;

  assign capture = (state_q == ST_IDLE) && i_rd_req;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (i_rd_req) state_q <= ST_VALID;
        ST_VALID: if (i_rd_ack) state_q <= ST_GAP;
        ST_GAP:   state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // An event landing on the capture edge survives the clear and shows up in the next read.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      flags_q   <= '0;
      rd_data_q <= '0;
    end else begin
      flags_q <= (flags_q & ~{N_FLAGS{capture}}) | i_evt;
      if (capture) rd_data_q <= flags_q;
    end
  end

`ifdef STATUS_FLAG_CNT_EN
  logic [CNT_WIDTH-1:0]         cnt_q [N_FLAGS];
  logic [N_FLAGS*CNT_WIDTH-1:0] rd_cnt_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < N_FLAGS; i++) cnt_q[i] <= '0;
      rd_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_FLAGS; i++) begin
        if (capture) begin
          cnt_q[i] <= CNT_WIDTH'(i_evt[i]);
          rd_cnt_q[i*CNT_WIDTH +: CNT_WIDTH] <= cnt_q[i];
        end else if (i_evt[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_rd_cnt = rd_cnt_q;
`else
  assign o_rd_cnt = '0;
`endif

  assign o_rd_valid = (state_q == ST_VALID);
  assign o_rd_data  = rd_data_q;
  assign o_irq      = |(flags_q & ~i_mask);
  assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_status_flag_reader.sv
// Directed bench for status_flag_reader (N_FLAGS=8, CNT_WIDTH=4); counter checks follow STATUS_FLAG_CNT_EN.
module tb_status_flag_reader;

  logic        i_clk = 1'b0;
  logic        i_arst_n;
  logic [7:0]  i_evt;
  logic [7:0]  i_mask;
  logic        i_rd_req;
  logic        i_rd_ack;
  logic        o_rd_valid;
  logic [7:0]  o_rd_data;
  logic [31:0] o_rd_cnt;
  logic        o_irq;
  logic        o_busy;

  int n_checks = 0;
  int n_errors = 0;

  status_flag_reader #(.N_FLAGS(8), .CNT_WIDTH(4)) dut (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_evt      (i_evt),
    .i_mask     (i_mask),
    .i_rd_req   (i_rd_req),
    .i_rd_ack   (i_rd_ack),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .o_rd_cnt   (o_rd_cnt),
    .o_irq      (o_irq),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Ack the current VALID snapshot and return to IDLE through GAP.
  task automatic finish_read();
    i_rd_ack = 1'b1;
    tick();
    i_rd_ack = 1'b0;
    tick();
  endtask

  initial begin
    i_arst_n = 1'b0;
    i_evt    = '0;
    i_mask   = '0;
    i_rd_req = 1'b0;
    i_rd_ack = 1'b0;
    #12;
    chk("rst_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_data",  32'(o_rd_data),  32'd0);
    chk("rst_cnt",   o_rd_cnt,        32'd0);
    chk("rst_irq",   32'(o_irq),      32'd0);
    chk("rst_busy",  32'(o_busy),     32'd0);
    i_arst_n = 1'b1;
    tick();

    // Basic set and read-and-clear
    i_evt = 8'h05;
    tick();
    i_evt = 8'h00;
    chk("t1_irq_set",  32'(o_irq),      32'd1);
    chk("t1_idle",     32'(o_busy),     32'd0);
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    chk("t1_valid",    32'(o_rd_valid), 32'd1);
    chk("t1_data",     32'(o_rd_data),  32'h05);
    chk("t1_irq_clr",  32'(o_irq),      32'd0);
    chk("t1_busy",     32'(o_busy),     32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_hold_valid", 32'(o_rd_valid), 32'd1);
      chk("t1_hold_data",  32'(o_rd_data),  32'h05);
    end
    i_rd_ack = 1'b1;
    tick();
    i_rd_ack = 1'b0;
    chk("t1_gap_valid", 32'(o_rd_valid), 32'd0);
    chk("t1_gap_busy",  32'(o_busy),     32'd1);
    chk("t1_gap_data",  32'(o_rd_data),  32'h05);
    tick();
    chk("t1_idle_busy", 32'(o_busy),     32'd0);

    // Mask gates irq only
    i_mask = 8'hFF;
    i_evt  = 8'h80;
    tick();
    i_evt  = 8'h00;
    chk("t2_masked_irq", 32'(o_irq), 32'd0);
    i_mask = 8'h00;
    #1;
    chk("t2_unmask_irq", 32'(o_irq), 32'd1);
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    chk("t2_data", 32'(o_rd_data), 32'h80);
    finish_read();

    // Event on the capture edge wins over the clear
    i_evt = 8'h01;
    tick();
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    i_evt    = 8'h00;
    chk("t3_data1",     32'(o_rd_data), 32'h01);
    chk("t3_flag_kept", 32'(o_irq),     32'd1);
    finish_read();
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    chk("t3_data2",     32'(o_rd_data), 32'h01);
    chk("t3_irq_clr",   32'(o_irq),     32'd0);
    finish_read();

    // Counter saturation (or tie-off)
    i_evt = 8'h04;
    for (int i = 0; i < 20; i++) tick();
    i_evt = 8'h00;
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    chk("t4_data", 32'(o_rd_data), 32'h04);
`ifdef STATUS_FLAG_CNT_EN
    chk("t4_cnt_sat", o_rd_cnt, 32'h0000_0F00);
`else
    chk("t4_cnt_tied", o_rd_cnt, 32'd0);
`endif
    finish_read();
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    chk("t4_data_empty", 32'(o_rd_data), 32'h00);
    chk("t4_cnt_empty",  o_rd_cnt,       32'd0);
    finish_read();

    // Reset while a snapshot is pending
    i_evt = 8'hAA;
    tick();
    i_evt = 8'h00;
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    i_evt = 8'h11;
    tick();
    i_evt = 8'h00;
    chk("t5_pre_valid", 32'(o_rd_valid), 32'd1);
    chk("t5_pre_data",  32'(o_rd_data),  32'hAA);
    i_arst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(o_rd_valid), 32'd0);
    chk("t5_rst_data",  32'(o_rd_data),  32'd0);
    chk("t5_rst_busy",  32'(o_busy),     32'd0);
    chk("t5_rst_irq",   32'(o_irq),      32'd0);
    #2;
    i_arst_n = 1'b1;
    tick();
    i_rd_req = 1'b1;
    tick();
    chk("t5_snap_valid", 32'(o_rd_valid), 32'd1);
    chk("t5_snap_data",  32'(o_rd_data),  32'd0);

    // Back-to-back reads: req held, ack after one VALID cycle -> V,G,I repeating
    i_rd_ack = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t6_valid", 32'(o_rd_valid), (i % 3 == 2) ? 32'd1 : 32'd0);
      chk("t6_busy",  32'(o_busy),     (i % 3 == 1) ? 32'd0 : 32'd1);
    end
    i_rd_req = 1'b0;
    tick();
    i_rd_ack = 1'b0;
    tick();
    chk("t6_end_busy", 32'(o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/status_flag_reader.md
# status_flag_reader

Collects single-cycle event pulses from the LVDS link datapath (CRC error, symbol error, FIFO overflow, link-up/down, etc.) into sticky flag bits. It provides an atomic read-and-clear snapshot to the control/host side through a valid/ack handshake. It also drives a maskable interrupt line. It sits between the transceiver status sources and the register/host interface, and is the consumer end of the set/hold flag scheme used throughout the transceiver.

## Interface
- N_FLAGS, 8, number of sticky flag bits (1..32)
- CNT_WIDTH, 8, width of each per-flag event counter; only used with `STATUS_FLAG_CNT_EN`
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous, active-low reset
- i_evt  in  N_FLAGS  event pulses, one bit per flag, sampled every rising edge
- i_mask  in  N_FLAGS  1 = flag excluded from o_irq (does not block flag setting)
- i_rd_req  in  1  read request, level-sampled
- i_rd_ack  in  1  read acknowledge, level-sampled
- o_rd_valid  out  1  snapshot valid
- o_rd_data  out  N_FLAGS  flag snapshot
- o_rd_cnt  out  N_FLAGS*CNT_WIDTH  counter snapshot, flag i at bits [i*CNT_WIDTH +: CNT_WIDTH]
- o_irq  out  1  OR of (flags & ~i_mask)
- o_busy  out  1  state machine not in IDLE

## Operation
- Reset state:
  - flags = 0, counters = 0, state IDLE
  - o_rd_valid = 0, o_rd_data = 0, o_rd_cnt = 0
  - o_irq = 0, o_busy = 0
- Flag update every edge: flag_next = (flag & ~clr) | i_evt.
  - clr = all-ones mask of captured bits on the capture edge, else 0.
  - A set arriving on the clear edge wins: the bit stays 1 and is reported on the next read.
- o_irq is combinational from the flag registers and i_mask.
- FSM states IDLE, VALID, GAP:
  - IDLE: on i_rd_req=1, capture flag→o_rd_data, clear flags, go to VALID. With STATUS_FLAG_CNT_EN, also capture counters→o_rd_cnt and clear them.
  - VALID: o_rd_valid=1, o_rd_data and o_rd_cnt held stable. On i_rd_ack=1, go to GAP.
  - GAP: o_rd_valid=0 for exactly one cycle, then go to IDLE, regardless of i_rd_req.
- i_rd_req outside IDLE is ignored. i_rd_ack outside VALID is ignored. Simultaneous req+ack in IDLE counts as a req only.
- o_rd_data and o_rd_cnt keep their last snapshot after the read and change only at the next capture.
- Reset mid-read: immediate return to the reset state; the pending snapshot and all flags are discarded.

## Timing
- Event at edge k: flag=1 and o_irq=1 (if unmasked) after edge k.
- i_rd_req sampled high in IDLE at edge k: o_rd_valid=1 and data valid after edge k, i.e. 1 cycle latency.
- i_rd_ack sampled high in VALID at edge m: o_rd_valid=0 after edge m. The earliest next capture is at edge m+2.
- Minimum read period is 3 cycles.
- o_busy is high after the capture edge through the end of GAP.

## Configuration
- `STATUS_FLAG_CNT_EN` defined: one CNT_WIDTH-bit saturating counter per flag.
  - Increments on every edge with i_evt[i]=1 and holds at 2^CNT_WIDTH−1.
  - On the capture edge the counter loads i_evt[i] (0 or 1), so the clear follows the same event-wins rule as the flags.
- `STATUS_FLAG_CNT_EN` undefined:
  - No counter logic.
  - o_rd_cnt tied to 0.
  - CNT_WIDTH is unused; the port remains present.

## Test plan
- Reset, then pulse i_evt=8'h05 for 1 cycle, then i_rd_req=1 → o_rd_valid rises 1 cycle later with o_rd_data=8'h05 and o_irq falls to 0. Hold 4 cycles, assert i_rd_ack → o_rd_valid=0, o_busy drops 2 cycles after ack.
- i_mask=8'hFF, i_evt=8'h80 → flag set, o_irq=0. Clear i_mask → o_irq=1 the same cycle.
- i_evt=8'h01 on the exact capture edge (flag0 already set) → snapshot 8'h01, flag0 still 1 afterward. A second read returns 8'h01.
- With STATUS_FLAG_CNT_EN and CNT_WIDTH=4: i_evt[2] high for 20 cycles, then read → o_rd_cnt[11:8]=4'hF. Read again with no events → 0.
- Assert i_arst_n=0 while in VALID → o_rd_valid=0, o_rd_data=0, flags=0, o_busy=0. After release, i_rd_req → snapshot 0.
- Hold i_rd_req=1 continuously with ack after 1 cycle in VALID → reads occur every 3 cycles and the GAP cycle is always observed.
